// File: rtl/mem_arb_pkg.sv
// Shared types for the 2:1 memory arbiter: FSM states, owner encoding and
// the default starvation limit for the instruction port.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 4;

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter and priority override: data wins by default, inst wins once
// STARVE_LIMIT data grants have gone by while inst was waiting. Decision is combinational.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_inst
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          at_limit;

  assign at_limit   = (starve_cnt == LIMIT);
  assign grant_inst = inst_req && (!data_req || at_limit);

  // Only a data grant that bypasses a waiting inst request counts as starvation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (grant_inst || !inst_req) begin
        starve_cnt <= '0;
      end else if (!at_limit) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_2x1.sv
// Two-requester (inst/data) to one memory port arbiter, one transaction in flight.
// Latency: grant one cycle after request; addr/data handshakes pass straight through.
module mem_arbiter_2x1
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       any_req;
  logic       grant_inst;
  logic       req_act;
  logic       addr_ok;
  logic       data_ok;
  logic       is_inst;

  assign any_req = inst_req | data_req;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_en  ((state_q == ST_IDLE) && any_req),
    .grant_inst(grant_inst)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DATA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_act = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ADDR;
          owner_d = grant_inst ? OWN_INST : OWN_DATA;
        end
      end
      ST_ADDR: begin
        req_act = 1'b1;
        addr_ok = mem_addr_ok;
        // A slave may complete address and data in the same cycle.
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            data_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        data_ok = mem_data_ok;
        if (mem_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign is_inst = (owner_q == OWN_INST);

  // Handshakes are masked while reset is held so an in-flight beat cannot leak out.
  assign mem_req      = req_act & rst;
  assign inst_addr_ok = addr_ok & rst & is_inst;
  assign data_addr_ok = addr_ok & rst & ~is_inst;
  assign inst_data_ok = data_ok & rst & is_inst;
  assign data_data_ok = data_ok & rst & ~is_inst;

  assign mem_wr    = is_inst ? inst_wr    : data_wr;
  assign mem_size  = is_inst ? inst_size  : data_size;
  assign mem_addr  = is_inst ? inst_addr  : data_addr;
  assign mem_wdata = is_inst ? inst_wdata : data_wdata;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Bench for mem_arbiter_2x1: directed protocol cases, then randomized traffic
// checked by a scoreboard against a request-level arbitration model.
module tb_mem_arbiter_2x1;

  localparam int LIM = 4;
  localparam logic [31:0] KEY = 32'h5A5A_1234;

  logic        clk, rst;
  logic        r_req[2], r_wr[2];
  logic [1:0]  r_size[2];
  logic [31:0] r_addr[2], r_wdata[2];
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  mem_arbiter_2x1 #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(r_req[0]), .inst_wr(r_wr[0]), .inst_size(r_size[0]),
    .inst_addr(r_addr[0]), .inst_wdata(r_wdata[0]), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(r_req[1]), .data_wr(r_wr[1]), .data_size(r_size[1]),
    .data_addr(r_addr[1]), .data_wdata(r_wdata[1]), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench-side requester, slave and model state.
  logic        seen_aok[2], seen_dok[2], outst[2];
  logic        mon_on, issue_on, stray_on, slv_real;
  int          iss_pct;
  logic        s_in_addr, s_in_data;
  int          s_cnt;
  logic [31:0] s_addr;
  logic [31:0] exp_q0[$], exp_q1[$];
  bit          grant_log[$];
  logic        prev_ireq, prev_dreq, prev_mreq;
  bit          cur_own;   // 1 = data owns the bus
  int          m_starve;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    mon_on = 1'b0; issue_on = 1'b0; stray_on = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0; slv_real = 1'b0;
    s_in_addr = 1'b0; s_in_data = 1'b0; s_cnt = 0; s_addr = '0;
    for (int r = 0; r < 2; r++) begin
      r_req[r] = 1'b0; r_wr[r] = 1'b0; r_size[r] = 2'd0; r_addr[r] = '0; r_wdata[r] = '0;
      outst[r] = 1'b0;
    end
    exp_q0.delete(); exp_q1.delete(); grant_log.delete();
    m_starve = 0; cur_own = 1'b1;
    at_neg();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One cycle of requester and slave behaviour, driven just after the rising edge.
  task automatic drive_step();
    for (int r = 0; r < 2; r++) begin
      if (seen_aok[r]) begin
        r_req[r] = 1'b0;
        outst[r] = !seen_dok[r];
      end else if (seen_dok[r]) begin
        outst[r] = 1'b0;
      end
      if (issue_on && !r_req[r] && !outst[r] && ($urandom_range(0, 99) < iss_pct)) begin
        r_req[r]   = 1'b1;
        r_wr[r]    = 1'($urandom_range(0, 1));
        r_size[r]  = 2'($urandom_range(0, 3));
        r_addr[r]  = $urandom;
        r_wdata[r] = $urandom;
        if (r == 0) exp_q0.push_back(r_addr[r] ^ KEY);
        else        exp_q1.push_back(r_addr[r] ^ KEY);
      end
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; slv_real = 1'b0; mem_rdata = $urandom;
    if (s_in_data) begin
      if (s_cnt == 0) begin
        mem_data_ok = 1'b1; slv_real = 1'b1; mem_rdata = s_addr ^ KEY; s_in_data = 1'b0;
      end else begin
        s_cnt--;
      end
    end else begin
      if (mem_req && !s_in_addr) begin
        s_in_addr = 1'b1;
        s_cnt = $urandom_range(0, 2);
      end
      if (s_in_addr) begin
        if (s_cnt == 0) begin
          mem_addr_ok = 1'b1; s_addr = mem_addr; s_in_addr = 1'b0;
          if ($urandom_range(0, 2) == 0) begin
            mem_data_ok = 1'b1; slv_real = 1'b1; mem_rdata = mem_addr ^ KEY;
          end else begin
            s_in_data = 1'b1;
            s_cnt = $urandom_range(0, 2);
          end
        end else begin
          s_cnt--;
          if (stray_on && $urandom_range(0, 3) == 0) mem_data_ok = 1'b1;
        end
      end else if (stray_on && !mem_req && $urandom_range(0, 7) == 0) begin
        mem_data_ok = 1'b1;
      end
    end
  endtask

  task automatic drain();
    issue_on = 1'b0;
    for (int i = 0; i < 300 && (r_req[0] || r_req[1] || outst[0] || outst[1] || s_in_addr || s_in_data); i++) begin
      tick();
      drive_step();
    end
    chk("drain_idle", {26'd0, r_req[0], r_req[1], outst[0], outst[1], s_in_addr, s_in_data}, 32'd0);
    chk("inst_q_empty", exp_q0.size(), 32'd0);
    chk("data_q_empty", exp_q1.size(), 32'd0);
    tick();
    mon_on = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  // Monitor / scoreboard: request-level view of who should own each bus tenure.
  always @(negedge clk) begin
    seen_aok[0] = inst_addr_ok; seen_aok[1] = data_addr_ok;
    seen_dok[0] = inst_data_ok; seen_dok[1] = data_data_ok;
    if (mon_on) begin
      if (mem_req && !prev_mreq) begin
        bit win;
        win = prev_dreq && !(prev_ireq && m_starve == LIM);
        chk("grant_had_req", {31'd0, prev_ireq | prev_dreq}, 32'd1);
        m_starve = (win && prev_ireq) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        cur_own = win;
        grant_log.push_back(win);
        chk("grant_addr", mem_addr, r_addr[win]);
        chk("grant_wr", {31'd0, mem_wr}, {31'd0, r_wr[win]});
        chk("grant_size", {30'd0, mem_size}, {30'd0, r_size[win]});
        chk("grant_wdata", mem_wdata, r_wdata[win]);
      end
      if (mem_req && mem_addr_ok)
        chk("aok_route", {30'd0, inst_addr_ok, data_addr_ok}, cur_own ? 32'd1 : 32'd2);
      else if (inst_addr_ok || data_addr_ok)
        chk("aok_spurious", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      if (mem_data_ok && slv_real)
        chk("dok_route", {30'd0, inst_data_ok, data_data_ok}, cur_own ? 32'd1 : 32'd2);
      else if (mem_data_ok || inst_data_ok || data_data_ok)
        chk("dok_stray", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      if (inst_data_ok) begin
        if (exp_q0.size() == 0) chk("inst_dok_unexpected", 32'd1, 32'd0);
        else chk("inst_rdata", inst_rdata, exp_q0.pop_front());
      end
      if (data_data_ok) begin
        if (exp_q1.size() == 0) chk("data_dok_unexpected", 32'd1, 32'd0);
        else chk("data_rdata", data_rdata, exp_q1.pop_front());
      end
    end
    prev_ireq = r_req[0];
    prev_dreq = r_req[1];
    prev_mreq = mem_req;
  end

  initial begin
    string pat;
    rst = 1'b0;
    mon_on = 1'b0;
    prev_ireq = 1'b0; prev_dreq = 1'b0; prev_mreq = 1'b0;
    iss_pct = 0;
    do_reset();

    // Inst-only read with a slow slave.
    tick(); r_req[0] = 1'b1; r_wr[0] = 1'b0; r_size[0] = 2'd2; r_addr[0] = 32'h0000_1000;
    at_neg(); chk("t1_idle_mreq", {31'd0, mem_req}, 32'd0);
    tick(); at_neg();
    chk("t1_mreq", {31'd0, mem_req}, 32'd1);
    chk("t1_maddr", mem_addr, 32'h0000_1000);
    chk("t1_mwr", {31'd0, mem_wr}, 32'd0);
    tick(); mem_addr_ok = 1'b1;
    at_neg(); chk("t1_aok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    tick(); mem_addr_ok = 1'b0; r_req[0] = 1'b0;
    at_neg();
    chk("t1_data_mreq", {31'd0, mem_req}, 32'd0);
    chk("t1_no_dok_yet", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    tick(); mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    at_neg();
    chk("t1_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    chk("t1_rdata", inst_rdata, 32'hDEAD_BEEF);
    tick(); mem_data_ok = 1'b0;

    // Simultaneous requests: data write first with a zero-latency slave, then inst.
    tick();
    r_req[0] = 1'b1; r_wr[0] = 1'b0; r_addr[0] = 32'h0000_2000;
    r_req[1] = 1'b1; r_wr[1] = 1'b1; r_size[1] = 2'd2; r_addr[1] = 32'h8000_0010; r_wdata[1] = 32'h1234_5678;
    tick(); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
    at_neg();
    chk("t2_mwr", {31'd0, mem_wr}, 32'd1);
    chk("t2_maddr", mem_addr, 32'h8000_0010);
    chk("t2_mwdata", mem_wdata, 32'h1234_5678);
    chk("t2_aok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    chk("t2_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    tick(); r_req[1] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    at_neg(); chk("t2_idle_after_zl", {31'd0, mem_req}, 32'd0);
    tick(); at_neg();
    chk("t2_inst_mreq", {31'd0, mem_req}, 32'd1);
    chk("t2_inst_maddr", mem_addr, 32'h0000_2000);
    tick(); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0000_CAFE;
    at_neg();
    chk("t2_inst_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    chk("t2_inst_rdata", inst_rdata, 32'h0000_CAFE);
    tick(); r_req[0] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    // Reset during DATA, then a stale data_ok, then normal arbitration.
    tick(); r_req[0] = 1'b1; r_addr[0] = 32'h0000_3000; r_wr[0] = 1'b0;
    tick(); mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; r_req[0] = 1'b0;
    tick(); rst = 1'b0; mem_data_ok = 1'b1;
    at_neg();
    chk("t3_rst_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t3_rst_mreq", {31'd0, mem_req}, 32'd0);
    tick(); rst = 1'b1;
    at_neg();
    chk("t3_stale_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t3_idle_mreq", {31'd0, mem_req}, 32'd0);
    tick(); mem_data_ok = 1'b0; r_req[1] = 1'b1; r_wr[1] = 1'b0; r_addr[1] = 32'h0000_4000;
    tick(); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0000_4444;
    at_neg();
    chk("t3_new_mreq", {31'd0, mem_req}, 32'd1);
    chk("t3_new_maddr", mem_addr, 32'h0000_4000);
    chk("t3_new_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    tick(); r_req[1] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    // Randomized traffic with stray data_ok pulses.
    do_reset();
    mon_on = 1'b1; issue_on = 1'b1; stray_on = 1'b1; iss_pct = 40;
    repeat (2000) begin
      tick();
      drive_step();
    end
    drain();

    // Both requesters saturated: inst must get through every STARVE_LIMIT+1 grants.
    do_reset();
    mon_on = 1'b1; issue_on = 1'b1; stray_on = 1'b0; iss_pct = 100;
    for (int i = 0; i < 400 && grant_log.size() < 10; i++) begin
      tick();
      drive_step();
    end
    drain();
    pat = "DDDDIDDDDI";
    if (grant_log.size() < 10) begin
      chk("starve_grant_count", grant_log.size(), 32'd10);
    end else begin
      for (int i = 0; i < 10; i++)
        chk("starve_order", grant_log[i] ? 32'h44 : 32'h49, {24'd0, pat[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2x1.md
MEM_ARBITER_2X1 -- requirements
Module: mem_arbiter_2x1

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants allowed while inst_req is pending.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-low.
REQ-004 SHALL have ports {inst,data}_req, input, 1, requester request; held until the matching addr_ok.
REQ-005 SHALL have ports {inst,data}_wr, input, 1, requester write (1) or read (0).
REQ-006 SHALL have ports {inst,data}_size, input, 2, requester access size.
REQ-007 SHALL have ports {inst,data}_addr and {inst,data}_wdata, input, 32, requester address and write data.
REQ-008 SHALL have ports {inst,data}_rdata, output, 32, read data returned to the requester.
REQ-009 SHALL have ports {inst,data}_addr_ok and {inst,data}_data_ok, output, 1, per-requester handshakes.
REQ-010 SHALL have ports mem_req, mem_wr, mem_size(2), mem_addr(32), mem_wdata(32), output, as the shared downstream request.
REQ-011 SHALL have ports mem_rdata(32), mem_addr_ok(1), mem_data_ok(1), input, as the shared downstream response.

Function
REQ-012 SHALL use FSM states IDLE, ADDR, DATA and a registered owner flag (INST/DATA); at most one transaction outstanding.
REQ-013 In IDLE with any request pending, SHALL register the owner and enter ADDR next cycle; mem_req SHALL be 0 in IDLE.
REQ-014 Arbitration SHALL be fixed priority data over inst, except inst SHALL win when starve_cnt == STARVE_LIMIT and inst_req = 1.
REQ-015 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each data grant with inst_req = 1, and clear on any inst grant or data grant with inst_req = 0.
REQ-016 In ADDR, mem_req SHALL be 1 and mem_wr/size/addr/wdata SHALL combinationally follow the owner's inputs.
REQ-017 In ADDR, owner's addr_ok SHALL equal mem_addr_ok; the non-owner's addr_ok SHALL be 0; on mem_addr_ok, SHALL go to DATA.
REQ-018 In DATA, owner's data_ok SHALL equal mem_data_ok; on mem_data_ok, SHALL return to IDLE; mem_req SHALL be 0.
REQ-019 If mem_addr_ok and mem_data_ok coincide in ADDR, SHALL deliver the owner's addr_ok and data_ok in that cycle and go to IDLE.
REQ-020 mem_data_ok in IDLE, or in ADDR without mem_addr_ok, SHALL be ignored; no data_ok is forwarded.
REQ-021 inst_rdata and data_rdata SHALL both equal mem_rdata; they are valid only with the respective data_ok.
REQ-022 Minimum latency: request seen in cycle N -> mem_req in N+1 -> earliest data_ok in N+1 (REQ-019), otherwise in the cycle of mem_data_ok.
REQ-023 A requester that drops req during ADDR is a protocol violation; behaviour is unspecified and is not checked.

Reset
REQ-024 On rst = 0 at a clock edge, SHALL force IDLE, owner = DATA, and starve_cnt = 0.
REQ-025 During and after reset, mem_req and all addr_ok/data_ok outputs SHALL be 0.
REQ-026 Reset mid-transaction SHALL abort it silently; a later stale mem_data_ok SHALL be ignored per REQ-020.

Structure
REQ-027 State encoding (IDLE/ADDR/DATA), owner encoding, and the STARVE_LIMIT default SHALL live in the shared package mem_arb_pkg.
REQ-028 A single sub-module, arb_starve_ctr, SHALL hold starve_cnt and the priority-override decision; the FSM and muxing stay in the top.

Verification
REQ-029 Inst-only read: inst_req, addr 0x0000_1000, with mem addr_ok next cycle and data_ok 2 cycles later with rdata 0xDEAD_BEEF -> mem_req in cycle 1; inst_data_ok with 0xDEAD_BEEF; data_* handshakes stay 0.
REQ-030 Simultaneous inst_req and data_req, data write 0x8000_0010 -> data granted first, mem_wr = 1, mem_addr = 0x8000_0010; inst served next transaction.
REQ-031 inst_req held with data_req held continuously, STARVE_LIMIT = 4 -> grants D,D,D,D,I,D... and starve_cnt returns to 0 after the inst grant.
REQ-032 Zero-latency slave (mem_addr_ok = mem_data_ok = 1 in the same cycle) -> owner gets addr_ok and data_ok in that cycle; FSM back to IDLE next cycle.
REQ-033 rst = 0 asserted in DATA, then a stray mem_data_ok -> all outputs 0; no data_ok delivered; next request arbitrates normally from IDLE.
